core_acc_arb: RTL and testbench

//  Round-robin arbiter/sequencer sharing one core_acc instance among NUM_REQ psum producers.

---
 rtl/core_acc_arb.sv | 228 ++++++++++++++++++++++
 tb/tb_core_acc_arb.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_acc_arb.sv
// ---------------------------------------------------------------------------
// core_acc_arb
// Round-robin arbiter/sequencer that shares one core_acc among NUM_REQ psum
// producers. A granted requester owns a whole accumulation group of
// L = cfg_acc_num + 2 beats, streamed one per cycle without stalls. The group
// length seen by core_acc comes from a copy of cfg_acc_num latched at grant.
// Each returned sum is routed back to the requester that owned the group.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   cfg_acc_num       group config, sampled when a grant is made
//   req_data          beat of requester i at [i*IDATA_BIT +: IDATA_BIT]
//   req_valid         requester i has a beat
//   req_ready         beat of requester i is taken this cycle (combinational)
//   acc_cfg_acc_num   latched config to core_acc
//   acc_idata(_valid) registered beat stream to core_acc
//   acc_odata(_valid) accumulated sum returned by core_acc
//   rsp_data          routed sum, shared by all requesters
//   rsp_valid         one-hot owner of rsp_data, one-cycle pulse
//   grant_id          current / last owner
//   err_bubble        sticky: owner dropped req_valid inside its group
//   err_rsp           sticky: sum returned while no owner was queued
// ---------------------------------------------------------------------------
module core_acc_arb #(
    parameter int NUM_REQ   = 4,
    parameter int IDATA_BIT = 32,
    parameter int ODATA_BIT = 32,
    parameter int CDATA_BIT = 8,
    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [CDATA_BIT-1:0]           cfg_acc_num,
    input  logic [NUM_REQ*IDATA_BIT-1:0]   req_data,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic [CDATA_BIT-1:0]           acc_cfg_acc_num,
    output logic [IDATA_BIT-1:0]           acc_idata,
    output logic                           acc_idata_valid,
    input  logic [ODATA_BIT-1:0]           acc_odata,
    input  logic                           acc_odata_valid,
    output logic [ODATA_BIT-1:0]           rsp_data,
    output logic [NUM_REQ-1:0]             rsp_valid,
    output logic [GW-1:0]                  grant_id,
    output logic                           err_bubble,
    output logic                           err_rsp
);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } state_t;

    state_t                 state_r;
    state_t                 state_nxt_s;
    logic [GW-1:0]          rr_ptr_r;
    logic [GW-1:0]          winner_s;
    logic [GW-1:0]          cand_s;
    logic                   win_found_s;
    logic [GW-1:0]          grant_nxt_s;
    logic [CDATA_BIT:0]     beat_cnt_r;
    logic [CDATA_BIT:0]     last_beat_s;
    logic                   group_done_s;
    logic [IDATA_BIT-1:0]   sel_data_s;
    logic                   sel_valid_s;
    logic [GW-1:0]          fifo_mem_r [2];
    logic                   fifo_wr_r;
    logic                   fifo_rd_r;
    logic [1:0]             fifo_cnt_r;
    logic                   push_s;
    logic                   pop_s;

    // One-hot decode of a requester id.
    function automatic logic [NUM_REQ-1:0] onehot_f(input logic [GW-1:0] id);
        logic [NUM_REQ-1:0] oh;
        oh     = {NUM_REQ{1'b0}};
        oh[id] = 1'b1;
        return oh;
    endfunction

    // Round-robin search: first requesting index at or after the pointer.
    always_comb begin
        winner_s    = {GW{1'b0}};
        cand_s      = {GW{1'b0}};
        win_found_s = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand_s = GW'((int'(rr_ptr_r) + k) % NUM_REQ);
            if (!win_found_s && req_valid[cand_s]) begin
                win_found_s = 1'b1;
                winner_s    = cand_s;
            end else begin
                win_found_s = win_found_s;
            end
        end
    end

    // Owner's beat selection and group bookkeeping helpers.
    always_comb begin
        sel_data_s = {IDATA_BIT{1'b0}};
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant_id == GW'(k)) begin
                sel_data_s = req_data[k*IDATA_BIT +: IDATA_BIT];
            end else begin
                sel_data_s = sel_data_s;
            end
        end
        sel_valid_s = req_valid[grant_id];
        // L-1 = cfg + 1; the extra counter bit keeps cfg = all-ones from wrapping.
        last_beat_s  = {1'b0, acc_cfg_acc_num} + {{CDATA_BIT{1'b0}}, 1'b1};
        group_done_s = (state_r == ST_STREAM) && (beat_cnt_r == last_beat_s);
        grant_nxt_s  = (grant_id == GW'(NUM_REQ - 1)) ? {GW{1'b0}} : grant_id + {{(GW-1){1'b0}}, 1'b1};
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next state: IDLE always lasts at least one cycle between groups.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE:   state_nxt_s = win_found_s  ? ST_STREAM : ST_IDLE;
            ST_STREAM: state_nxt_s = group_done_s ? ST_IDLE   : ST_STREAM;
            default:   state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM outputs: the owner is ready on every cycle of its group.
    always_comb begin
        req_ready = {NUM_REQ{1'b0}};
        if (state_r == ST_STREAM) begin
            req_ready[grant_id] = 1'b1;
        end else begin
            req_ready = {NUM_REQ{1'b0}};
        end
    end

    // Grant, latched config, beat counter and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_id        <= {GW{1'b0}};
            acc_cfg_acc_num <= {CDATA_BIT{1'b0}};
            beat_cnt_r      <= {(CDATA_BIT+1){1'b0}};
            rr_ptr_r        <= {GW{1'b0}};
        end else if (state_r == ST_IDLE) begin
            if (win_found_s) begin
                grant_id        <= winner_s;
                acc_cfg_acc_num <= cfg_acc_num;
                beat_cnt_r      <= {(CDATA_BIT+1){1'b0}};
            end
        end else begin
            beat_cnt_r <= beat_cnt_r + {{CDATA_BIT{1'b0}}, 1'b1};
            if (group_done_s) begin
                rr_ptr_r <= grant_nxt_s;
            end
        end
    end

    // Beat stream to core_acc; a missing owner beat is zero-padded and flagged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_idata_valid <= 1'b0;
            acc_idata       <= {IDATA_BIT{1'b0}};
            err_bubble      <= 1'b0;
        end else if (state_r == ST_STREAM) begin
            acc_idata_valid <= 1'b1;
            if (sel_valid_s) begin
                acc_idata <= sel_data_s;
            end else begin
                acc_idata  <= {IDATA_BIT{1'b0}};
                err_bubble <= 1'b1;
            end
        end else begin
            acc_idata_valid <= 1'b0;
            acc_idata       <= {IDATA_BIT{1'b0}};
        end
    end

    assign pop_s  = acc_odata_valid && (fifo_cnt_r != 2'd0);
    assign push_s = group_done_s && ((fifo_cnt_r != 2'd2) || pop_s);

    // Owner id FIFO (depth 2) bridging group end to result return.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_mem_r[0] <= {GW{1'b0}};
            fifo_mem_r[1] <= {GW{1'b0}};
            fifo_wr_r     <= 1'b0;
            fifo_rd_r     <= 1'b0;
            fifo_cnt_r    <= 2'd0;
        end else begin
            if (push_s) begin
                fifo_mem_r[fifo_wr_r] <= grant_id;
                fifo_wr_r             <= ~fifo_wr_r;
            end
            if (pop_s) begin
                fifo_rd_r <= ~fifo_rd_r;
            end
            case ({push_s, pop_s})
                2'b10:   fifo_cnt_r <= fifo_cnt_r + 2'd1;
                2'b01:   fifo_cnt_r <= fifo_cnt_r - 2'd1;
                default: fifo_cnt_r <= fifo_cnt_r;
            endcase
        end
    end

    // Result routing: one-cycle one-hot pulse to the queued owner.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_data  <= {ODATA_BIT{1'b0}};
            rsp_valid <= {NUM_REQ{1'b0}};
            err_rsp   <= 1'b0;
        end else begin
            rsp_valid <= {NUM_REQ{1'b0}};
            if (pop_s) begin
                rsp_data  <= acc_odata;
                rsp_valid <= onehot_f(fifo_mem_r[fifo_rd_r]);
            end else if (acc_odata_valid) begin
                err_rsp <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_core_acc_arb.sv
module tb_core_acc_arb;
    localparam int NR = 4;
    localparam int IW = 32;
    localparam int OW = 32;
    localparam int CW = 8;
    localparam int GW = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [CW-1:0]     cfg_acc_num = '0;
    logic [NR*IW-1:0]  req_data = '0;
    logic [NR-1:0]     req_valid = '0;
    logic [NR-1:0]     req_ready;
    logic [CW-1:0]     acc_cfg_acc_num;
    logic [IW-1:0]     acc_idata;
    logic              acc_idata_valid;
    logic [OW-1:0]     acc_odata = '0;
    logic              acc_odata_valid = 1'b0;
    logic [OW-1:0]     rsp_data;
    logic [NR-1:0]     rsp_valid;
    logic [GW-1:0]     grant_id;
    logic              err_bubble;
    logic              err_rsp;

    core_acc_arb #(.NUM_REQ(NR), .IDATA_BIT(IW), .ODATA_BIT(OW), .CDATA_BIT(CW)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_acc_num(cfg_acc_num),
        .req_data(req_data), .req_valid(req_valid), .req_ready(req_ready),
        .acc_cfg_acc_num(acc_cfg_acc_num), .acc_idata(acc_idata),
        .acc_idata_valid(acc_idata_valid), .acc_odata(acc_odata),
        .acc_odata_valid(acc_odata_valid), .rsp_data(rsp_data),
        .rsp_valid(rsp_valid), .grant_id(grant_id),
        .err_bubble(err_bubble), .err_rsp(err_rsp)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model state (transaction level) ----------
    int            m_left = 0;     // beats still owed in the current group
    int            m_owner = 0;
    int            m_rr = 0;
    logic [CW-1:0] m_cfg = '0;
    logic [OW-1:0] m_sum = '0;
    bit            found;
    int            owner_q[$];
    logic [OW-1:0] sum_q[$];
    logic          exp_accv = 1'b0;
    logic [IW-1:0] exp_accd = '0;
    logic          exp_bub = 1'b0;
    logic          exp_err = 1'b0;
    logic [NR-1:0] exp_rspv = '0;
    logic [OW-1:0] exp_rspd = '0;
    logic [NR-1:0] exp_ready;
    // core_acc behavioural model
    logic [OW-1:0] c_sum = '0;
    int            c_cnt = 0;
    logic          p1_v = 1'b0, p2_v = 1'b0;
    logic [OW-1:0] p1_d = '0, p2_d = '0;
    logic          inj = 1'b0;

    // Monitor + core_acc model + scoreboard, evaluated mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("rst_req_ready", req_ready, 0);
                chk("rst_acc_valid", acc_idata_valid, 0);
                chk("rst_acc_idata", acc_idata, 0);
                chk("rst_acc_cfg", acc_cfg_acc_num, 0);
                chk("rst_rsp_valid", rsp_valid, 0);
                chk("rst_rsp_data", rsp_data, 0);
                chk("rst_grant_id", grant_id, 0);
                chk("rst_err_flags", {err_bubble, err_rsp}, 0);
                m_left = 0; m_rr = 0; m_sum = '0;
                owner_q.delete(); sum_q.delete();
                exp_accv = 1'b0; exp_bub = 1'b0; exp_err = 1'b0; exp_rspv = '0;
                c_sum = '0; c_cnt = 0; p1_v = 1'b0; p2_v = 1'b0; inj = 1'b0;
                acc_odata_valid = 1'b0; acc_odata = '0;
            end else begin
                exp_ready = '0;
                if (m_left > 0) exp_ready[m_owner] = 1'b1;
                chk("req_ready", req_ready, exp_ready);
                chk("acc_idata_valid", acc_idata_valid, exp_accv);
                if (exp_accv) chk("acc_idata", acc_idata, exp_accd);
                if (m_left > 0) begin
                    chk("grant_id", grant_id, m_owner);
                    chk("acc_cfg_acc_num", acc_cfg_acc_num, m_cfg);
                end
                chk("err_bubble", err_bubble, exp_bub);
                chk("rsp_valid", rsp_valid, exp_rspv);
                if (exp_rspv != 0) chk("rsp_data", rsp_data, exp_rspd);
                chk("err_rsp", err_rsp, exp_err);
                // core_acc: sum appears 2 cycles after the last beat of a group
                acc_odata_valid = p1_v | inj;
                acc_odata       = p1_v ? p1_d : 32'h0000_1234;
                exp_rspv = '0;
                if (acc_odata_valid) begin
                    if (owner_q.size() > 0) begin
                        exp_rspv[owner_q.pop_front()] = 1'b1;
                        exp_rspd = sum_q.pop_front();
                    end else begin
                        exp_err = 1'b1;
                    end
                end
                inj = 1'b0;
                p1_v = p2_v; p1_d = p2_d; p2_v = 1'b0;
                if (acc_idata_valid) begin
                    c_sum += acc_idata;
                    c_cnt++;
                    if (c_cnt == int'(acc_cfg_acc_num) + 2) begin
                        p2_v = 1'b1; p2_d = c_sum; c_sum = '0; c_cnt = 0;
                    end
                end
                // arbitration rules: a group is L beats, then one idle cycle
                exp_accv = 1'b0;
                if (m_left > 0) begin
                    exp_accv = 1'b1;
                    exp_accd = req_valid[m_owner] ? req_data[m_owner*IW +: IW] : '0;
                    if (!req_valid[m_owner]) exp_bub = 1'b1;
                    m_sum += exp_accd;
                    m_left--;
                    if (m_left == 0) begin
                        owner_q.push_back(m_owner);
                        sum_q.push_back(m_sum);
                        m_rr = (m_owner + 1) % NR;
                    end
                end else if (req_valid != 0) begin
                    found = 1'b0;
                    for (int k = 0; k < NR; k++) begin
                        if (!found && req_valid[(m_rr + k) % NR]) begin
                            found = 1'b1;
                            m_owner = (m_rr + k) % NR;
                        end
                    end
                    m_cfg  = cfg_acc_num;
                    m_left = int'(cfg_acc_num) + 2;
                    m_sum  = '0;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [IW:0]   srcq [NR][$];   // {valid, data} per requester
    logic [NR-1:0] last_ready;
    logic [NR-1:0] last_rspv;
    logic [OW-1:0] last_rspd;

    task automatic push(input int r, input logic v, input logic [IW-1:0] d);
        srcq[r].push_back({v, d});
    endtask

    task automatic drive();
        for (int i = 0; i < NR; i++) begin
            if (srcq[i].size() > 0) begin
                req_valid[i]         = srcq[i][0][IW];
                req_data[i*IW +: IW] = srcq[i][0][IW-1:0];
            end else begin
                req_valid[i]         = 1'b0;
                req_data[i*IW +: IW] = $urandom;
            end
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            last_ready = req_ready;
            last_rspv  = rsp_valid;
            last_rspd  = rsp_data;
            @(posedge clk);
            #1;
            for (int i = 0; i < NR; i++)
                if (last_ready[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
            drive();
        end
    endtask

    task automatic clear_src();
        for (int i = 0; i < NR; i++) srcq[i].delete();
        drive();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_src();
        cyc(2);
        rst_n = 1'b1;
        cyc(1);
    endtask

    task automatic wait_rsp(input string tag, input logic [NR-1:0] ev, input logic [OW-1:0] ed);
        int n = 0;
        do begin
            cyc(1);
            n++;
        end while (last_rspv == 0 && n < 60);
        chk({tag, "_rsp_valid"}, last_rspv, ev);
        chk({tag, "_rsp_data"}, last_rspd, ed);
    endtask

    initial begin
        int n;
        int taken;
        #1;
        do_reset();

        // 1: single requester, cfg=2 -> 4 beats summed
        cfg_acc_num = 8'd2;
        push(0, 1'b1, 32'd1); push(0, 1'b1, 32'd2); push(0, 1'b1, 32'd3); push(0, 1'b1, 32'd4);
        drive();
        wait_rsp("t1", 4'b0001, 32'd10);

        // 2: req0 and req2 together from a fresh pointer
        do_reset();
        cfg_acc_num = 8'd0;
        push(0, 1'b1, 32'd5); push(0, 1'b1, 32'd6);
        push(2, 1'b1, 32'd7); push(2, 1'b1, 32'd8);
        drive();
        wait_rsp("t2a", 4'b0001, 32'd11);
        wait_rsp("t2b", 4'b0100, 32'd15);

        // 3: all requesters busy -> order 0,1,2,3,0
        do_reset();
        cfg_acc_num = 8'd0;
        push(0, 1'b1, 32'd1);  push(0, 1'b1, 32'd2); push(0, 1'b1, 32'd100); push(0, 1'b1, 32'd200);
        push(1, 1'b1, 32'd10); push(1, 1'b1, 32'd20);
        push(2, 1'b1, 32'd30); push(2, 1'b1, 32'd40);
        push(3, 1'b1, 32'd50); push(3, 1'b1, 32'd60);
        drive();
        wait_rsp("t3_g0", 4'b0001, 32'd3);
        wait_rsp("t3_g1", 4'b0010, 32'd30);
        wait_rsp("t3_g2", 4'b0100, 32'd70);
        wait_rsp("t3_g3", 4'b1000, 32'd110);
        wait_rsp("t3_g4", 4'b0001, 32'd300);

        // 4: bubble on the third beat is zero-padded and flagged
        do_reset();
        cfg_acc_num = 8'd2;
        push(1, 1'b1, 32'd1); push(1, 1'b1, 32'd2); push(1, 1'b0, 32'hDEAD_BEEF); push(1, 1'b1, 32'd4);
        drive();
        wait_rsp("t4", 4'b0010, 32'd7);
        chk("t4_err_bubble", err_bubble, 1);

        // 5: signed data, cfg change mid-group has no effect on this group
        cfg_acc_num = 8'd0;
        push(0, 1'b1, -32'sd5); push(0, 1'b1, 32'sd3);
        drive();
        n = 0;
        do begin cyc(1); n++; end while (!last_ready[0] && n < 20);
        cfg_acc_num = 8'd3;
        wait_rsp("t5", 4'b0001, 32'hFFFF_FFFE);
        chk("t5_err_bubble_sticky", err_bubble, 1);

        // 6: reset during beat 2 of a cfg=4 group
        cfg_acc_num = 8'd4;
        for (int b = 0; b < 6; b++) push(3, 1'b1, 32'(11 + b));
        drive();
        taken = 0; n = 0;
        do begin cyc(1); n++; if (last_ready[3]) taken++; end while (taken < 2 && n < 20);
        rst_n = 1'b0;
        #1;
        chk("t6_async_outs", {req_ready, acc_idata_valid, grant_id, acc_cfg_acc_num, err_bubble}, 0);
        clear_src();
        cyc(2);
        rst_n = 1'b1;
        cfg_acc_num = 8'd0;
        push(0, 1'b1, 32'd9); push(0, 1'b1, 32'd1);
        push(3, 1'b1, 32'd2); push(3, 1'b1, 32'd3);
        drive();
        wait_rsp("t6_first", 4'b0001, 32'd10);
        wait_rsp("t6_second", 4'b1000, 32'd5);

        // randomized traffic with random config churn
        for (int c = 0; c < 1500; c++) begin
            for (int r = 0; r < NR; r++) begin
                if (srcq[r].size() == 0 && $urandom_range(0, 7) == 0) begin
                    int len;
                    len = $urandom_range(1, 8);
                    for (int b = 0; b < len; b++) push(r, 1'b1, $urandom);
                end
            end
            cfg_acc_num = CW'($urandom_range(0, 5));
            drive();
            cyc(1);
        end
        n = 0;
        while ((srcq[0].size() + srcq[1].size() + srcq[2].size() + srcq[3].size()) > 0 && n < 500) begin
            cyc(1);
            n++;
        end
        cyc(20);
        chk("scoreboard_drained", owner_q.size(), 0);

        // result with nothing outstanding -> err_rsp, no rsp_valid
        inj = 1'b1;
        cyc(2);
        chk("err_rsp_set", err_rsp, 1);
        chk("err_rsp_no_rsp", last_rspv, 0);
        cyc(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
